// File: rtl/piso_serializer.sv
// Parallel-in serial-out word serializer with frame markers.
// Feeds a 4-stage SISO shift register; idle gap eases re-alignment.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter int   GAP_CYCLES = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST =
    4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  shreg, shreg_n;
  logic [CW-1:0]     bit_cnt, bit_n;
  logic [3:0]        gap_cnt, gap_n;
  logic              hs;
  logic              sout_n;
  logic              ready_n;

  // Next state, shift register and counter update
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    hs      = din_valid && din_ready;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_n = SHIFT;
          shreg_n = din;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        if (bit_cnt == BIT_LAST) begin
          bit_n = '0;
          if (GAP_CYCLES > 0) begin
            state_n = GAP;
            gap_n   = '0;
          end else if (hs) begin
            state_n = SHIFT;
            shreg_n = din;
          end else begin
            state_n = IDLE;
          end
        end else begin
          bit_n   = bit_cnt + CW'(1);
          shreg_n = (MSB_FIRST != 0) ? (shreg << 1)
                                     : (shreg >> 1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_n = '0;
          if (hs) begin
            state_n = SHIFT;
            shreg_n = din;
            bit_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          gap_n = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_n = IDLE;
        bit_n   = '0;
        gap_n   = '0;
      end
    endcase
  end

  // Output values for the coming cycle
  always_comb begin
    sout_n = IDLE_LEVEL;
    if (state_n == SHIFT) begin
      sout_n = (MSB_FIRST != 0) ? shreg_n[WIDTH-1]
                                : shreg_n[0];
    end
    ready_n = (state_n == IDLE)
           || (state_n == GAP && gap_n == GAP_LAST)
           || (state_n == SHIFT && bit_n == BIT_LAST
               && GAP_CYCLES == 0);
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      sout        <= IDLE_LEVEL;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      busy        <= 1'b0;
      din_ready   <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_n;
      gap_cnt     <= gap_n;
      sout        <= sout_n;
      sout_valid  <= (state_n == SHIFT);
      frame_start <= (state_n == SHIFT) && (bit_n == '0);
      frame_end   <= (state_n == SHIFT) && (bit_n == BIT_LAST);
      busy        <= (state_n != IDLE);
      din_ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer.
// Four parameterisations share one clock and reset.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  // A: WIDTH=8 MSB_FIRST=1 GAP=1
  logic [7:0] a_din;
  logic a_valid, a_ready, a_sout, a_sv, a_fs, a_fe, a_busy;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_valid),
    .din_ready(a_ready), .sout(a_sout), .sout_valid(a_sv),
    .frame_start(a_fs), .frame_end(a_fe), .busy(a_busy));

  // L: LSB first, feeding a 4-stage SISO
  logic [7:0] l_din;
  logic l_valid, l_ready, l_sout, l_sv, l_fs, l_fe, l_busy;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1)) u_l (
    .clk(clk), .rst_n(rst_n), .din(l_din), .din_valid(l_valid),
    .din_ready(l_ready), .sout(l_sout), .sout_valid(l_sv),
    .frame_start(l_fs), .frame_end(l_fe), .busy(l_busy));

  logic [3:0] siso;
  always_ff @(posedge clk) siso <= {siso[2:0], l_sout};

  // G: no gap
  logic [7:0] g_din;
  logic g_valid, g_ready, g_sout, g_sv, g_fs, g_fe, g_busy;
  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_g (
    .clk(clk), .rst_n(rst_n), .din(g_din), .din_valid(g_valid),
    .din_ready(g_ready), .sout(g_sout), .sout_valid(g_sv),
    .frame_start(g_fs), .frame_end(g_fe), .busy(g_busy));

  // W: WIDTH=2 GAP=15
  logic [1:0] w_din;
  logic w_valid, w_ready, w_sout, w_sv, w_fs, w_fe, w_busy;
  piso_serializer #(.WIDTH(2), .MSB_FIRST(1), .GAP_CYCLES(15)) u_w (
    .clk(clk), .rst_n(rst_n), .din(w_din), .din_valid(w_valid),
    .din_ready(w_ready), .sout(w_sout), .sout_valid(w_sv),
    .frame_start(w_fs), .frame_end(w_fe), .busy(w_busy));

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    a_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if ({a_sout, a_sv, a_fs, a_fe, a_busy, a_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outs got=%b want=000000",
               {a_sout, a_sv, a_fs, a_fe, a_busy, a_ready});
    end
    a_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({a_ready, a_busy, a_sout} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release ready,busy,sout got=%b want=100",
               {a_ready, a_busy, a_sout});
    end
  endtask

  task automatic test_msb_word();
    logic [7:0] exp;
    exp = 8'hA5;
    a_din = 8'hA5;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    a_din = 8'h00;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (a_sout !== exp[7-i] || a_sv !== 1'b1) begin
        n_fail++;
        $display("FAIL msb_bit%0d sout,sv got=%b%b want=%b1",
                 i, a_sout, a_sv, exp[7-i]);
      end
      n_chk++;
      if (a_fs !== (i == 0) || a_fe !== (i == 7) || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL msb_frame%0d fs,fe,rdy got=%b%b%b want=%b%b0",
                 i, a_fs, a_fe, a_ready, i == 0, i == 7);
      end
      @(negedge clk);
    end
    n_chk++;
    if ({a_sv, a_ready, a_busy, a_sout} !== 4'b0110) begin
      n_fail++;
      $display("FAIL msb_gap sv,rdy,busy,sout got=%b want=0110",
               {a_sv, a_ready, a_busy, a_sout});
    end
    @(negedge clk);
    n_chk++;
    if ({a_sv, a_ready, a_busy} !== 3'b010) begin
      n_fail++;
      $display("FAIL msb_idle sv,rdy,busy got=%b want=010",
               {a_sv, a_ready, a_busy});
    end
  endtask

  task automatic test_lsb_siso();
    logic [7:0] exp;
    exp = 8'h01;
    l_din = 8'h01;
    l_valid = 1'b1;
    @(negedge clk);
    l_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 8) begin
        n_chk++;
        if (l_sout !== exp[i] || l_sv !== 1'b1) begin
          n_fail++;
          $display("FAIL lsb_bit%0d sout,sv got=%b%b want=%b1",
                   i, l_sout, l_sv, exp[i]);
        end
      end
      if (i >= 4) begin
        n_chk++;
        if (siso[3] !== exp[i-4]) begin
          n_fail++;
          $display("FAIL siso_dout%0d got=%b want=%b",
                   i - 4, siso[3], exp[i-4]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    g_din = 8'hFF;
    g_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      n_chk++;
      if (g_sout !== (i < 8) || g_sv !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_bit%0d sout,sv got=%b%b want=%b1",
                 i, g_sout, g_sv, i < 8);
      end
      n_chk++;
      if (g_fs !== (i == 0 || i == 8) || g_fe !== (i == 7 || i == 15)
          || g_ready !== (i == 7 || i == 15)) begin
        n_fail++;
        $display("FAIL b2b_frame%0d fs,fe,rdy got=%b%b%b", i,
                 g_fs, g_fe, g_ready);
      end
      if (i == 0) g_din = 8'h00;
      if (i == 15) g_valid = 1'b0;
      @(negedge clk);
    end
    n_chk++;
    if ({g_sv, g_busy, g_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL b2b_end sv,busy,rdy got=%b want=001",
               {g_sv, g_busy, g_ready});
    end
  endtask

  task automatic test_busy_pulse();
    logic [7:0] exp;
    exp = 8'h3C;
    a_din = 8'h3C;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (a_sout !== exp[7-i] || a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL pulse_bit%0d sout,rdy got=%b%b want=%b0",
                 i, a_sout, a_ready, exp[7-i]);
      end
      a_valid = (i == 2);
      a_din = 8'hFF;
      @(negedge clk);
    end
    a_valid = 1'b0;
    n_chk++;
    if ({a_sv, a_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL pulse_gap sv,rdy got=%b want=01", {a_sv, a_ready});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if ({a_sv, a_busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL pulse_noword%0d sv,busy got=%b want=00",
                 i, {a_sv, a_busy});
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] exp;
    exp = 8'hC3;
    a_din = 8'hC3;
    a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_chk++;
    if (a_sout !== exp[4] || a_sv !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_bit4 sout,sv got=%b%b want=%b1",
               a_sout, a_sv, exp[4]);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_sout, a_sv, a_fs, a_fe, a_busy, a_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL areset_outs got=%b want=000000",
               {a_sout, a_sv, a_fs, a_fe, a_busy, a_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({a_ready, a_sv, a_busy} !== 3'b100) begin
      n_fail++;
      $display("FAIL areset_release rdy,sv,busy got=%b want=100",
               {a_ready, a_sv, a_busy});
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_chk++;
      if ({a_sv, a_sout, a_busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL areset_residue%0d sv,sout,busy got=%b want=000",
                 i, {a_sv, a_sout, a_busy});
      end
    end
  endtask

  task automatic test_width2_gap15();
    w_din = 2'b10;
    w_valid = 1'b1;
    @(negedge clk);
    w_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (w_sout !== (i == 0) || w_sv !== 1'b1 || w_fs !== (i == 0)
          || w_fe !== (i == 1)) begin
        n_fail++;
        $display("FAIL w2_bit%0d sout,sv,fs,fe got=%b%b%b%b", i,
                 w_sout, w_sv, w_fs, w_fe);
      end
      @(negedge clk);
    end
    for (int j = 0; j < 15; j++) begin
      n_chk++;
      if (w_sv !== 1'b0 || w_busy !== 1'b1 || w_ready !== (j == 14)) begin
        n_fail++;
        $display("FAIL w2_gap%0d sv,busy,rdy got=%b%b%b want=01%b", j,
                 w_sv, w_busy, w_ready, j == 14);
      end
      @(negedge clk);
    end
    n_chk++;
    if ({w_sv, w_busy, w_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL w2_idle sv,busy,rdy got=%b want=001",
               {w_sv, w_busy, w_ready});
    end
  endtask

  initial begin
    a_din = '0; a_valid = 1'b0;
    l_din = '0; l_valid = 1'b0;
    g_din = '0; g_valid = 1'b0;
    w_din = '0; w_valid = 1'b0;
    test_reset();
    test_msb_word();
    test_lsb_siso();
    test_back_to_back();
    test_busy_pulse();
    test_async_reset();
    test_width2_gap15();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
